// File: rtl/harmonic_sequencer.sv
// Time-multiplexes one shared harmonic engine over NUM_HARM harmonics of the current note
// and emits one saturated 16-bit sample per rising edge of generate_next_sample.
module harmonic_sequencer #(
  parameter int NUM_HARM = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play_enable,
  input  logic                    note_done,
  input  logic                    generate_next_sample,
  input  logic [19:0]             step_size,
  input  logic [2*NUM_HARM-1:0]   weights,
  output logic                    h_start,
  output logic [1:0]              h_index,
  output logic [19:0]             h_step_size,
  output logic [1:0]              h_weight,
  output logic                    h_clear,
  input  logic signed [15:0]      h_sample,
  input  logic                    h_valid,
  output logic signed [15:0]      sample_out,
  output logic                    sample_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam int            TW     = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]    K_LAST = 2'(NUM_HARM - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                 state;
  logic                   gen_q;
  logic                   trigger;
  logic                   silent;
  logic                   adv;
  logic signed [17:0]     acc;
  logic [1:0]             k;
  logic [1:0]             nxt_k;
  logic [1:0]             cur_w;
  logic [1:0]             nxt_w;
  logic [19:0]            step_q;
  logic [2*NUM_HARM-1:0]  w_q;
  logic [7:0]             w_pad;
  logic [TW-1:0]          tcnt;

  function automatic logic [19:0] sat_add(input logic [19:0] a, input logic [19:0] b);
    logic [20:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[20] ? 20'hFFFFF : s[19:0];
  endfunction

  function automatic logic signed [15:0] clamp16(input logic signed [17:0] a);
    if (a > 18'sd32767)       return 16'sh7FFF;
    else if (a < -18'sd32768) return 16'sh8000;
    else                      return a[15:0];
  endfunction

  assign trigger = generate_next_sample & ~gen_q;
  assign busy    = (state != IDLE);
  assign nxt_k   = k + 2'd1;

  // Unused slots read as muted so the weight lookup never indexes past the latch.
  always_comb begin
    w_pad = '1;
    w_pad[2*NUM_HARM-1:0] = w_q;
  end

  assign cur_w = w_pad[{k, 1'b0} +: 2];
  assign nxt_w = w_pad[{nxt_k, 1'b0} +: 2];

  always_comb begin
    adv = 1'b0;
    if (play_enable) begin
      if (state == ISSUE)     adv = (cur_w == 2'd3);
      else if (state == WAIT) adv = h_valid || (tcnt == T_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      gen_q        <= 1'b0;
      silent       <= 1'b0;
      acc          <= '0;
      k            <= '0;
      step_q       <= '0;
      w_q          <= '0;
      tcnt         <= '0;
      h_start      <= 1'b0;
      h_index      <= '0;
      h_step_size  <= '0;
      h_weight     <= '0;
      h_clear      <= 1'b0;
      sample_out   <= '0;
      sample_ready <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      gen_q        <= generate_next_sample;
      h_start      <= 1'b0;
      h_clear      <= 1'b0;
      sample_ready <= 1'b0;
      overrun      <= trigger & (state != IDLE);

      case (state)
        IDLE: begin
          if (trigger) begin
            step_q      <= step_size;
            w_q         <= weights;
            acc         <= '0;
            k           <= '0;
            h_step_size <= step_size;
            silent      <= note_done | ~play_enable;
            if (note_done) begin
              h_clear <= 1'b1;
              state   <= DONE;
            end else if (!play_enable) begin
              state <= DONE;
            end else begin
              // The request is raised on entry so it is visible during ISSUE itself.
              h_index  <= '0;
              h_weight <= weights[1:0];
              h_start  <= (weights[1:0] != 2'd3);
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!play_enable) begin
            silent <= 1'b1;
            state  <= DONE;
          end else if (cur_w != 2'd3) begin
            tcnt  <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!play_enable) begin
            silent <= 1'b1;
            state  <= DONE;
          end else if (h_valid) begin
            acc <= acc + {{2{h_sample[15]}}, h_sample};
          end else if (tcnt != T_LAST) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          sample_out   <= silent ? 16'sd0 : clamp16(acc);
          sample_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Step to the next harmonic; the step keeps growing even across muted slots.
      if (adv) begin
        if (k == K_LAST) begin
          state <= DONE;
        end else begin
          k           <= nxt_k;
          h_index     <= nxt_k;
          h_weight    <= nxt_w;
          h_step_size <= sat_add(h_step_size, step_q);
          h_start     <= (nxt_w != 2'd3);
          state       <= ISSUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Directed bench for harmonic_sequencer: vector table plus hand sequences for abort,
// overrun and asynchronous reset, against a small engine model with per-slot latency.
module tb_harmonic_sequencer;
  localparam int NH = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               play_enable = 1'b0;
  logic               note_done = 1'b0;
  logic               gen = 1'b0;
  logic [19:0]        step_size = '0;
  logic [2*NH-1:0]    weights = '0;
  logic               h_start, h_clear, sample_ready, busy, overrun;
  logic [1:0]         h_index, h_weight;
  logic [19:0]        h_step_size;
  logic               h_valid = 1'b0;
  logic signed [15:0] h_sample = '0;
  logic signed [15:0] sample_out;

  harmonic_sequencer #(.NUM_HARM(NH), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .note_done(note_done),
    .generate_next_sample(gen), .step_size(step_size), .weights(weights),
    .h_start(h_start), .h_index(h_index), .h_step_size(h_step_size), .h_weight(h_weight),
    .h_clear(h_clear), .h_sample(h_sample), .h_valid(h_valid),
    .sample_out(sample_out), .sample_ready(sample_ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: answers lat[idx] cycles after seeing h_start, unless that slot is silent.
  int         resp [4];
  int         lat [4];
  logic [3:0] sil = '0;
  logic       armed = 1'b0;
  int         wait_n = 0;
  logic [1:0] pidx = '0;

  always @(negedge clk) begin
    if (armed && wait_n <= 1) begin
      h_valid  <= 1'b1;
      h_sample <= 16'(resp[pidx]);
      armed    <= 1'b0;
    end else begin
      h_valid <= 1'b0;
      if (armed) wait_n <= wait_n - 1;
    end
    if (h_start && !sil[h_index]) begin
      armed  <= 1'b1;
      wait_n <= lat[h_index];
      pidx   <= h_index;
    end
  end

  typedef struct {
    logic [1:0]  idx;
    logic [19:0] step;
    logic [1:0]  w;
  } st_t;

  st_t st_q[$];
  int  rdy_cyc[$];
  int  rdy_val[$];
  int  clr_cyc[$];
  int  ovr_cnt = 0;

  always @(negedge clk) begin
    if (h_start) st_q.push_back('{h_index, h_step_size, h_weight});
    if (sample_ready) begin
      rdy_cyc.push_back(cyc);
      rdy_val.push_back(int'(sample_out));
    end
    if (h_clear) clr_cyc.push_back(cyc);
    if (overrun) ovr_cnt <= ovr_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_step(input logic [19:0] s, input int k);
    longint p;
    p = longint'(s) * (k + 1);
    return (p > 1048575) ? 1048575 : int'(p);
  endfunction

  typedef struct {
    logic [19:0]     step;
    logic [2*NH-1:0] w;
    logic            play;
    logic            nd;
    int              r0;
    int              r1;
    int              r2;
    logic [3:0]      sil;
    int              exp_out;
    int              exp_cyc;
  } vec_t;

  vec_t tv [10];

  task automatic setup(input vec_t v);
    step_size   = v.step;
    weights     = v.w;
    play_enable = v.play;
    note_done   = v.nd;
    resp[0] = v.r0; resp[1] = v.r1; resp[2] = v.r2; resp[3] = 0;
    lat[0] = 1; lat[1] = 1; lat[2] = 1; lat[3] = 1;
    sil = v.sil;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int s0, r0, c0, o0, t0, e;
    string nm;
    nm = $sformatf("v%0d", id);
    @(negedge clk);
    setup(v);
    s0 = st_q.size(); r0 = rdy_cyc.size(); c0 = clr_cyc.size(); o0 = ovr_cnt;
    gen = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 300 && rdy_cyc.size() == r0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    gen = 1'b0;
    repeat (3) @(negedge clk);
    chk({nm, ".ready_count"}, rdy_cyc.size() - r0, 1);
    if (rdy_cyc.size() > r0) begin
      chk({nm, ".sample_out"}, rdy_val[r0], v.exp_out);
      chk({nm, ".ready_cycle"}, rdy_cyc[r0] - t0, v.exp_cyc);
    end
    e = 0;
    if (v.play && !v.nd) begin
      for (int k = 0; k < NH; k++) begin
        if (v.w[2*k +: 2] != 2'd3) begin
          if (s0 + e < st_q.size()) begin
            chk($sformatf("%s.h_index%0d", nm, e), int'(st_q[s0+e].idx), k);
            chk($sformatf("%s.h_step%0d", nm, e), int'(st_q[s0+e].step), exp_step(v.step, k));
            chk($sformatf("%s.h_weight%0d", nm, e), int'(st_q[s0+e].w), int'(v.w[2*k +: 2]));
          end
          e++;
        end
      end
    end
    chk({nm, ".start_count"}, st_q.size() - s0, e);
    chk({nm, ".clear_count"}, clr_cyc.size() - c0, int'(v.nd));
    if (v.nd && clr_cyc.size() > c0) chk({nm, ".clear_cycle"}, clr_cyc[c0] - t0, 1);
    chk({nm, ".overrun"}, ovr_cnt - o0, 0);
  endtask

  initial begin
    int r0, o0, t0;
    tv[0] = '{20'd500,    6'b000000, 1'b1, 1'b0, 1000,   2000,   3000,   4'b0000, 6000,   8};
    tv[1] = '{20'd500,    6'b000000, 1'b1, 1'b0, 20000,  20000,  20000,  4'b0000, 32767,  8};
    tv[2] = '{20'd500,    6'b000000, 1'b1, 1'b0, -20000, -20000, -20000, 4'b0000, -32768, 8};
    tv[3] = '{20'd700,    6'b001100, 1'b1, 1'b0, 1000,   2000,   3000,   4'b0000, 4000,   7};
    tv[4] = '{20'd500,    6'b000000, 1'b0, 1'b0, 1000,   2000,   3000,   4'b0000, 0,      2};
    tv[5] = '{20'd500,    6'b000000, 1'b1, 1'b1, 1000,   2000,   3000,   4'b0000, 0,      2};
    tv[6] = '{20'd500,    6'b000000, 1'b1, 1'b0, 1000,   2000,   3000,   4'b0100, 3000,   71};
    tv[7] = '{20'hFFFFF,  6'b000000, 1'b1, 1'b0, 1,      1,      1,      4'b0000, 3,      8};
    tv[8] = '{20'h60000,  6'b100100, 1'b1, 1'b0, 100,    -300,   50,     4'b0000, -150,   8};
    tv[9] = '{20'd500,    6'b111111, 1'b1, 1'b0, 1000,   2000,   3000,   4'b0000, 0,      5};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset.sample_out", int'(sample_out), 0);
    chk("reset.sample_ready", int'(sample_ready), 0);
    chk("reset.h_start", int'(h_start), 0);
    chk("reset.h_clear", int'(h_clear), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.overrun", int'(overrun), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(tv[i], i);

    // Abort: play_enable drops while waiting on harmonic 1; the late answer is ignored.
    @(negedge clk);
    setup(tv[0]);
    lat[1] = 4;
    r0 = rdy_cyc.size();
    gen = 1'b1;
    t0 = cyc;
    repeat (4) @(negedge clk);
    chk("abort.h_index", int'(h_index), 1);
    play_enable = 1'b0;
    repeat (8) @(negedge clk);
    gen = 1'b0;
    chk("abort.ready_count", rdy_cyc.size() - r0, 1);
    if (rdy_cyc.size() > r0) begin
      chk("abort.sample_out", rdy_val[r0], 0);
      chk("abort.ready_cycle", rdy_cyc[r0] - t0, 6);
    end
    chk("abort.held_out", int'(sample_out), 0);
    chk("abort.busy", int'(busy), 0);
    play_enable = 1'b1;
    lat[1] = 1;
    repeat (2) @(negedge clk);

    // Overrun: second rising edge while waiting on harmonic 0.
    @(negedge clk);
    setup(tv[0]);
    r0 = rdy_cyc.size(); o0 = ovr_cnt;
    gen = 1'b1;
    t0 = cyc;
    @(negedge clk); gen = 1'b0;
    @(negedge clk); gen = 1'b1;
    for (int i = 0; i < 300 && rdy_cyc.size() == r0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    gen = 1'b0;
    repeat (3) @(negedge clk);
    chk("overrun.pulses", ovr_cnt - o0, 1);
    chk("overrun.ready_count", rdy_cyc.size() - r0, 1);
    if (rdy_cyc.size() > r0) begin
      chk("overrun.sample_out", rdy_val[r0], 6000);
      chk("overrun.ready_cycle", rdy_cyc[r0] - t0, 8);
    end

    // Asynchronous reset while waiting on harmonic 1.
    @(negedge clk);
    setup(tv[0]);
    r0 = rdy_cyc.size();
    gen = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("areset.sample_out", int'(sample_out), 0);
    chk("areset.sample_ready", int'(sample_ready), 0);
    chk("areset.h_start", int'(h_start), 0);
    chk("areset.busy", int'(busy), 0);
    chk("areset.h_step_size", int'(h_step_size), 0);
    chk("areset.h_index", int'(h_index), 0);
    gen = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("areset.no_ready", rdy_cyc.size() - r0, 0);
    run_vec(tv[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
